la_capture_core: RTL and testbench
==================================

// Module: la_capture_core
// PURPOSE
//  Parametrised embedded logic-analyser capture engine: samples DATA_W probe bits every sys_clk into a
//  DEPTH-entry circular buffer, evaluates a masked multi-bit edge/level trigger, and keeps a
//  programmable pre-trigger window. Sits behind the JTAG control bridge; the captured window is read
//  out oldest-first with a simple request/valid handshake.
// PARAMETERS
//  DATA_W  9     probe data width
//  TRIG_W  4     trigger input width
//  DEPTH   1024  samples in buffer; power of two, >=4; ADDR_W = $clog2(DEPTH) (localparam)
// PORTS
//  sys_clk       in   1       capture and readout clock
//  sys_rst       in   1       synchronous reset, active-high
//  data_i        in   DATA_W  probe samples
//  trig_i        in   TRIG_W  trigger inputs
//  arm_i         in   1       start capture (honoured only in IDLE)
//  force_trig_i  in   1       unconditional trigger (honoured only in WAIT)
//  trig_mask_i   in   TRIG_W  1 = bit participates in trigger
//  trig_val_i    in   TRIG_W  target value per bit
//  trig_edge_i   in   TRIG_W  1 = edge into trig_val (prev!=val, cur==val); 0 = level (cur==val)
//  trig_any_i    in   1       1 = OR of masked bits, 0 = AND of masked bits
//  pretrig_i     in   ADDR_W  pre-trigger samples; latched at arm, clamped to DEPTH-1
//  rd_en_i       in   1       read-request pulse (honoured only in DONE)
//  rd_data_o     out  DATA_W  read sample
//  rd_valid_o    out  1       rd_data_o valid (1-cycle pulse)
//  rd_last_o     out  1       with rd_valid_o: final (DEPTH-th) sample
//  armed_o       out  1       state is PRE, WAIT or POST
//  triggered_o   out  1       trigger seen this capture (POST or DONE)
//  done_o        out  1       state is DONE, buffer readable
//  trig_addr_o   out  ADDR_W  buffer address of trigger sample
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; pointers/counters 0; trig_q 0. Reset in any state aborts.
//  - trig_q registers trig_i every cycle (incl. IDLE) for edge detection.
//  - Trigger cond: masked bits AND (trig_any_i=0) or OR (=1); trig_mask_i==0 -> cond true.
//  - FSM:
//    IDLE: arm_i -> PRE (pretrig>0) else WAIT; latch pretrig, wr_ptr=0. Write starts the next cycle.
//    PRE: write data_i at wr_ptr, wr_ptr++; trigger ignored; after pretrig writes -> WAIT.
//    WAIT: write every cycle (wrap mod DEPTH). On cond|force_trig_i: that cycle's sample is the
//      trigger sample, trig_addr=wr_ptr, triggered_o=1; -> POST, or DONE if pretrig==DEPTH-1.
//    POST: write DEPTH-1-pretrig further samples, then -> DONE; writes stop.
//    DONE: rd_ptr starts at trig_addr-pretrig (mod DEPTH). rd_en_i -> rd_data_o/rd_valid_o next
//      cycle, rd_ptr++. rd_en_i is accepted every cycle (back-to-back reads allowed). rd_last_o
//      on the DEPTH-th read; the cycle after the last rd_valid_o -> IDLE (done_o,triggered_o=0).
//  - rd_en_i outside DONE, arm_i outside IDLE, force_trig_i outside WAIT: ignored.
//  - Buffer: single-port-per-side sync RAM (one write port, one read port, read latency 1).
// CONFIGURATION
//  LA_STORAGE_QUAL_EN defined: adds port qual_i (in, 1). PRE/WAIT/POST write and advance
//   wr_ptr/counters only when qual_i=1; trigger is evaluated only on qualified cycles; trig_q updates
//   only on qualified cycles.
//  Undefined: no qual_i port; every cycle is qualified.
// TESTING (DATA_W=8, TRIG_W=2, DEPTH=16; data_i=8-bit counter, 0x00 on first cycle after arm)
//  1 pretrig=4, mask=01, val=01, edge=01, bit0 rises at sample 0x0A -> reads 0x06..0x15,
//    trig_addr_o=0x0A, rd_last_o with 0x15.
//  2 bit0 held high from sample 0x01, pretrig=4: edge mode -> no trigger within 40 cycles;
//    level mode -> trigger at 0x04, reads 0x00..0x0F.
//  3 mask=00, pretrig=0 -> trigger at sample 0x00, reads 0x00..0x0F, done_o after 16 writes.
//  4 mask=11, val=11, level, bit0 high at 0x08, bit1 at 0x0C: any=0 -> trigger 0x0C; any=1 -> 0x08.
//  5 sys_rst mid-POST -> all outputs 0 next cycle; re-arm captures a clean window per scenario 1.
//  6 LA_STORAGE_QUAL_EN, qual_i=1 on even cycles only, mask=00, pretrig=0 -> reads 0x00,0x02,..,0x1E.

Source files
------------

// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: circular sample buffer, masked edge/level trigger, pre-trigger window.
// Optional storage qualification is enabled by defining LA_STORAGE_QUAL_EN (adds port qual_i).
module la_capture_core #(
  parameter int DATA_W = 9,
  parameter int TRIG_W = 4,
  parameter int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
`ifdef LA_STORAGE_QUAL_EN
  input  logic              qual_i,
`endif
  input  logic [DATA_W-1:0] data_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic              arm_i,
  input  logic              force_trig_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic [TRIG_W-1:0] trig_val_i,
  input  logic [TRIG_W-1:0] trig_edge_i,
  input  logic              trig_any_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              rd_last_o,
  output logic              armed_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, cnt, pretrig;
  logic [ADDR_W:0]   rd_cnt;
  logic [TRIG_W-1:0] trig_q, hit;
  logic              qual, cond, fire, wr_en, rd_fire, pre_done, post_done;

`ifdef LA_STORAGE_QUAL_EN
  assign qual = qual_i;
`else
  assign qual = 1'b1;
`endif

  // Per-bit match: level needs cur==val; edge additionally needs prev!=val.
  assign hit  = ~(trig_i ^ trig_val_i) & ~(trig_edge_i & ~(trig_q ^ trig_val_i));
  assign cond = (trig_mask_i == '0) ||
                (trig_any_i ? |(hit & trig_mask_i) : &(hit | ~trig_mask_i));
  assign fire = qual && (cond || force_trig_i);

  assign pre_done  = (cnt == pretrig - ONE);
  assign post_done = (cnt == ADDR_W'(DEPTH - 2) - pretrig);
  assign wr_en     = qual && (state == S_PRE || state == S_WAIT || state == S_POST);
  assign rd_fire   = (state == S_DONE) && rd_en_i && !rd_cnt[ADDR_W];

  assign armed_o = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign done_o  = (state == S_DONE);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (arm_i) state_d = (pretrig_i != '0) ? S_PRE : S_WAIT;
      S_PRE:  if (qual && pre_done) state_d = S_WAIT;
      S_WAIT: if (fire) state_d = (&pretrig) ? S_DONE : S_POST;
      S_POST: if (qual && post_done) state_d = S_DONE;
      S_DONE: if (rd_valid_o && rd_last_o) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the sample storage carries no reset; only control state and outputs are cleared.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      pretrig     <= '0;
      rd_cnt      <= '0;
      trig_q      <= '0;
      trig_addr_o <= '0;
      triggered_o <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_last_o   <= 1'b0;
      rd_data_o   <= '0;
    end else begin
      state      <= state_d;
      rd_valid_o <= rd_fire;
      rd_last_o  <= rd_fire && (rd_cnt == (ADDR_W + 1)'(DEPTH - 1));
      if (qual) trig_q <= trig_i;
      if (wr_en) wr_ptr <= wr_ptr + ONE;
      if (rd_fire) begin
        rd_data_o <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + ONE;
        rd_cnt    <= rd_cnt + 1'b1;
      end
      case (state)
        S_IDLE: if (arm_i) begin
          // pretrig_i is ADDR_W bits wide, so it can never exceed DEPTH-1.
          pretrig <= pretrig_i;
          wr_ptr  <= '0;
          cnt     <= '0;
          rd_cnt  <= '0;
        end
        S_PRE:  if (qual) cnt <= pre_done ? '0 : cnt + ONE;
        S_WAIT: if (fire) begin
          trig_addr_o <= wr_ptr;
          rd_ptr      <= wr_ptr - pretrig;
          triggered_o <= 1'b1;
          cnt         <= '0;
        end
        S_POST: if (qual) cnt <= cnt + ONE;
        S_DONE: if (state_d == S_IDLE) triggered_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core (DATA_W=8, TRIG_W=2, DEPTH=16); data_i is a sample counter.
// Build with LA_STORAGE_QUAL_EN defined to also exercise storage qualification.
module tb_la_capture_core;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       qual_i;
  logic [7:0] data_i;
  logic [1:0] trig_i, trig_mask_i, trig_val_i, trig_edge_i;
  logic       arm_i, force_trig_i, trig_any_i, rd_en_i;
  logic [3:0] pretrig_i;
  logic [7:0] rd_data_o;
  logic       rd_valid_o, rd_last_o, armed_o, triggered_o, done_o;
  logic [3:0] trig_addr_o;

  int passed = 0;
  int total  = 0;
  int last_n;

  always #5 sys_clk = ~sys_clk;

  la_capture_core #(.DATA_W(8), .TRIG_W(2), .DEPTH(16)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
`ifdef LA_STORAGE_QUAL_EN
    .qual_i(qual_i),
`endif
    .data_i(data_i),
    .trig_i(trig_i),
    .arm_i(arm_i),
    .force_trig_i(force_trig_i),
    .trig_mask_i(trig_mask_i),
    .trig_val_i(trig_val_i),
    .trig_edge_i(trig_edge_i),
    .trig_any_i(trig_any_i),
    .pretrig_i(pretrig_i),
    .rd_en_i(rd_en_i),
    .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o),
    .rd_last_o(rd_last_o),
    .armed_o(armed_o),
    .triggered_o(triggered_o),
    .done_o(done_o),
    .trig_addr_o(trig_addr_o)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic arm(input logic [3:0] pre, input logic [1:0] mask, input logic [1:0] val,
                     input logic [1:0] edg, input logic any);
    pretrig_i   = pre;
    trig_mask_i = mask;
    trig_val_i  = val;
    trig_edge_i = edg;
    trig_any_i  = any;
    trig_i      = 2'b00;
    arm_i       = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  // Streams samples n = start .. stop-1, stopping early once the capture is done.
  task automatic run(input int start, input int stop, input int b0, input int b1,
                     input int force_at, input bit even_qual, output int last);
    last = -1;
    for (int n = start; n < stop; n++) begin
      data_i       = 8'(n);
      trig_i[0]    = (n >= b0);
      trig_i[1]    = (n >= b1);
      force_trig_i = (n == force_at);
      qual_i       = even_qual ? (n % 2 == 0) : 1'b1;
      tick();
      last = n;
      if (done_o) break;
    end
    force_trig_i = 1'b0;
    trig_i       = 2'b00;
    qual_i       = 1'b1;
  endtask

  task automatic read_all(input string tag, input int first, input int step);
    for (int i = 0; i < 16; i++) begin
      rd_en_i = 1'b1;
      tick();
      check(tag, {rd_valid_o, rd_last_o, rd_data_o}, {1'b1, i == 15, 8'(first + i * step)});
    end
    rd_en_i = 1'b0;
    tick();
    check({tag, "_idle"}, {armed_o, triggered_o, done_o, rd_valid_o}, 4'b0000);
  endtask

  initial begin
    sys_rst = 1'b1; qual_i = 1'b1; data_i = '0; trig_i = '0; arm_i = 1'b0;
    force_trig_i = 1'b0; trig_mask_i = '0; trig_val_i = '0; trig_edge_i = '0;
    trig_any_i = 1'b0; pretrig_i = '0; rd_en_i = 1'b0;
    tick();
    tick();
    check("reset", {rd_valid_o, rd_last_o, armed_o, triggered_o, done_o, trig_addr_o, rd_data_o}, '0);
    sys_rst = 1'b0;
    tick();

    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
    check("rd_in_idle", {rd_valid_o, done_o}, 2'b00);

    // Rising edge on bit0 at sample 0x0A, four pre-trigger samples.
    arm(4'd4, 2'b01, 2'b01, 2'b01, 1'b0);
    check("s1_armed", {armed_o, triggered_o, done_o}, 3'b100);
    run(0, 40, 10, 1000, -1, 1'b0, last_n);
    check("s1_status", {armed_o, triggered_o, done_o}, 3'b011);
    check("s1_trig_addr", trig_addr_o, 4'hA);
    check("s1_last_write", last_n, 32'h15);
    read_all("s1_rd", 'h06, 1);

    // Bit0 already high when the trigger window opens: edge mode never fires, then force it.
    arm(4'd4, 2'b01, 2'b01, 2'b01, 1'b0);
    run(0, 40, 1, 1000, -1, 1'b0, last_n);
    check("s2_edge_no_trig", {armed_o, triggered_o, done_o}, 3'b100);
    run(40, 80, 1, 1000, 40, 1'b0, last_n);
    check("s2_force_addr", trig_addr_o, 4'h8);
    read_all("s2_force_rd", 'h24, 1);

    arm(4'd4, 2'b01, 2'b01, 2'b00, 1'b0);
    run(0, 40, 1, 1000, -1, 1'b0, last_n);
    check("s2_level_addr", trig_addr_o, 4'h4);
    read_all("s2_level_rd", 'h00, 1);

    // Empty mask with no pre-trigger: first sample triggers, done after 16 writes.
    arm(4'd0, 2'b00, 2'b00, 2'b00, 1'b0);
    run(0, 40, 1000, 1000, -1, 1'b0, last_n);
    check("s3_last_write", last_n, 32'h0F);
    check("s3_status", {triggered_o, done_o, trig_addr_o}, {2'b11, 4'h0});
    read_all("s3_rd", 'h00, 1);

    // AND versus OR of two level-triggered bits.
    arm(4'd4, 2'b11, 2'b11, 2'b00, 1'b0);
    run(0, 40, 8, 12, -1, 1'b0, last_n);
    check("s4_and_addr", trig_addr_o, 4'hC);
    read_all("s4_and_rd", 'h08, 1);
    arm(4'd4, 2'b11, 2'b11, 2'b00, 1'b1);
    run(0, 40, 8, 12, -1, 1'b0, last_n);
    check("s4_or_addr", trig_addr_o, 4'h8);
    read_all("s4_or_rd", 'h04, 1);

    // Reset in the middle of the post-trigger phase, then a clean re-capture.
    arm(4'd4, 2'b01, 2'b01, 2'b01, 1'b0);
    run(0, 14, 10, 1000, -1, 1'b0, last_n);
    check("s5_mid_post", {armed_o, triggered_o, done_o}, 3'b110);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("s5_reset", {rd_valid_o, rd_last_o, armed_o, triggered_o, done_o, trig_addr_o, rd_data_o}, '0);
    tick();
    arm(4'd4, 2'b01, 2'b01, 2'b01, 1'b0);
    run(0, 40, 10, 1000, -1, 1'b0, last_n);
    check("s5_trig_addr", trig_addr_o, 4'hA);
    read_all("s5_rd", 'h06, 1);

`ifdef LA_STORAGE_QUAL_EN
    // Only even-numbered samples are qualified for storage.
    arm(4'd0, 2'b00, 2'b00, 2'b00, 1'b0);
    run(0, 40, 1000, 1000, -1, 1'b1, last_n);
    check("s6_last_write", last_n, 32'h1E);
    read_all("s6_rd", 'h00, 2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
